// File: rtl/wb_csr_commit.sv
// Write-back commit controller: drives the CSR file port, reports exceptions and ertn,
// performs regfile write-back, and issues the flush/redirect followed by a fixed drain window.
module wb_csr_commit #(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned CNT_W        = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    output logic        wb_allowin,
    input  logic [31:0] mem_pc,
    input  logic [2:0]  mem_op,
    input  logic [13:0] mem_csr_num,
    input  logic [31:0] mem_rj_value,
    input  logic [31:0] mem_rkd_value,
    input  logic        mem_rf_we,
    input  logic [4:0]  mem_dest,
    input  logic [31:0] mem_result,
    input  logic        mem_ex,
    input  logic [5:0]  mem_ecode,
    input  logic [8:0]  mem_esubcode,
    input  logic [31:0] mem_vaddr,
    output logic        csr_re,
    output logic        csr_we,
    output logic [13:0] csr_num,
    output logic [31:0] csr_wmask,
    output logic [31:0] csr_wvalue,
    input  logic [31:0] csr_rvalue,
    output logic [31:0] wb_pc,
    output logic        wb_ex,
    output logic [5:0]  wb_ecode,
    output logic [8:0]  wb_esubcode,
    output logic [31:0] wb_vaddr,
    output logic        ertn_flush,
    input  logic        has_int,
    input  logic [31:0] ex_entry,
    input  logic [31:0] csr_era,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        flush,
    output logic [31:0] flush_target
);

    localparam logic [2:0] OpCsrrd   = 3'd1;
    localparam logic [2:0] OpCsrwr   = 3'd2;
    localparam logic [2:0] OpCsrxchg = 3'd3;
    localparam logic [2:0] OpErtn    = 3'd4;

    typedef enum logic {StRun, StDrain} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;
    logic             wb_valid_q, wb_valid_d;
    logic             capture;

    logic [31:0] pc_q, rj_q, rkd_q, result_q, vaddr_q;
    logic [2:0]  op_q;
    logic [13:0] num_q;
    logic        rf_we_q, ex_q;
    logic [4:0]  dest_q;
    logic [5:0]  ecode_q;
    logic [8:0]  esub_q;

    logic is_wr, is_xchg, is_csr, is_ertn, int_take, ex;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StRun;
            drain_cnt_q <= '0;
            wb_valid_q  <= 1'b0;
            pc_q        <= '0;
            op_q        <= '0;
            num_q       <= '0;
            rj_q        <= '0;
            rkd_q       <= '0;
            rf_we_q     <= 1'b0;
            dest_q      <= '0;
            result_q    <= '0;
            ex_q        <= 1'b0;
            ecode_q     <= '0;
            esub_q      <= '0;
            vaddr_q     <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            wb_valid_q  <= wb_valid_d;
            if (capture) begin
                pc_q     <= mem_pc;
                op_q     <= mem_op;
                num_q    <= mem_csr_num;
                rj_q     <= mem_rj_value;
                rkd_q    <= mem_rkd_value;
                rf_we_q  <= mem_rf_we;
                dest_q   <= mem_dest;
                result_q <= mem_result;
                ex_q     <= mem_ex;
                ecode_q  <= mem_ecode;
                esub_q   <= mem_esubcode;
                vaddr_q  <= mem_vaddr;
            end
        end
    end

    // A flush always wins over capture: the instruction arriving on the flush edge is wrong-path.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        wb_valid_d  = 1'b0;
        capture     = 1'b0;
        unique case (state_q)
            StRun: begin
                if (flush) begin
                    state_d     = StDrain;
                    drain_cnt_d = CNT_W'(DRAIN_CYCLES);
                end else if (mem_valid) begin
                    capture    = 1'b1;
                    wb_valid_d = 1'b1;
                end
            end
            StDrain: begin
                if (drain_cnt_q == CNT_W'(1)) begin
                    state_d     = StRun;
                    drain_cnt_d = '0;
                end else begin
                    drain_cnt_d = drain_cnt_q - CNT_W'(1);
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_comb begin
        is_wr    = (op_q == OpCsrwr);
        is_xchg  = (op_q == OpCsrxchg);
        is_csr   = (op_q == OpCsrrd) | is_wr | is_xchg;
        is_ertn  = (op_q == OpErtn);
        int_take = wb_valid_q & has_int;
        ex       = int_take | (wb_valid_q & ex_q);

        wb_allowin  = 1'b1;
        wb_ex       = ex;
        wb_pc       = wb_valid_q ? pc_q : 32'h0;
        wb_ecode    = (wb_valid_q & ~int_take) ? ecode_q : 6'h0;
        wb_esubcode = (wb_valid_q & ~int_take) ? esub_q : 9'h0;
        wb_vaddr    = (wb_valid_q & ~int_take) ? vaddr_q : 32'h0;
        ertn_flush  = wb_valid_q & is_ertn & ~ex;

        csr_re     = wb_valid_q & is_csr & ~ex;
        csr_we     = wb_valid_q & (is_wr | is_xchg) & ~ex;
        csr_num    = (wb_valid_q & is_csr) ? num_q : 14'h0;
        csr_wmask  = 32'h0;
        if (wb_valid_q && is_wr) begin
            csr_wmask = 32'hFFFF_FFFF;
        end else if (wb_valid_q && is_xchg) begin
            csr_wmask = rj_q;
        end
        csr_wvalue = csr_we ? rkd_q : 32'h0;

        rf_we    = wb_valid_q & rf_we_q & ~ex & (dest_q != 5'd0);
        rf_waddr = wb_valid_q ? dest_q : 5'd0;
        // CSR ops return the old CSR value to the destination GPR.
        rf_wdata = wb_valid_q ? (is_csr ? csr_rvalue : result_q) : 32'h0;

        flush        = ex | ertn_flush;
        flush_target = ex ? ex_entry : (ertn_flush ? csr_era : 32'h0);
    end

endmodule

// File: tb/tb_wb_csr_commit.sv
// Bench for wb_csr_commit: table-driven commit vectors through a scoreboard queue, plus
// hand-written drain, interrupt-while-idle and reset-mid-drain sequences.
module tb_wb_csr_commit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mem_valid, wb_allowin;
    logic [31:0] mem_pc, mem_rj_value, mem_rkd_value, mem_result, mem_vaddr;
    logic [2:0]  mem_op;
    logic [13:0] mem_csr_num, csr_num;
    logic        mem_rf_we, mem_ex;
    logic [4:0]  mem_dest, rf_waddr;
    logic [5:0]  mem_ecode, wb_ecode;
    logic [8:0]  mem_esubcode, wb_esubcode;
    logic        csr_re, csr_we, wb_ex, ertn_flush, has_int, rf_we, flush;
    logic [31:0] csr_wmask, csr_wvalue, csr_rvalue, wb_pc, wb_vaddr, ex_entry, csr_era;
    logic [31:0] rf_wdata, flush_target;

    int checks = 0;
    int errors = 0;

    wb_csr_commit #(.DRAIN_CYCLES(3), .CNT_W(4)) dut (
        .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .wb_allowin(wb_allowin),
        .mem_pc(mem_pc), .mem_op(mem_op), .mem_csr_num(mem_csr_num),
        .mem_rj_value(mem_rj_value), .mem_rkd_value(mem_rkd_value), .mem_rf_we(mem_rf_we),
        .mem_dest(mem_dest), .mem_result(mem_result), .mem_ex(mem_ex), .mem_ecode(mem_ecode),
        .mem_esubcode(mem_esubcode), .mem_vaddr(mem_vaddr), .csr_re(csr_re), .csr_we(csr_we),
        .csr_num(csr_num), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
        .csr_rvalue(csr_rvalue), .wb_pc(wb_pc), .wb_ex(wb_ex), .wb_ecode(wb_ecode),
        .wb_esubcode(wb_esubcode), .wb_vaddr(wb_vaddr), .ertn_flush(ertn_flush),
        .has_int(has_int), .ex_entry(ex_entry), .csr_era(csr_era), .rf_we(rf_we),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .flush(flush), .flush_target(flush_target)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] pc;
        logic [13:0] num;
        logic [31:0] rj, rkd;
        logic        rfwe;
        logic [4:0]  dest;
        logic [31:0] result;
        logic        ex;
        logic [5:0]  ecode;
        logic [8:0]  esub;
        logic [31:0] vaddr;
        logic        hint;
        logic [31:0] rvalue, entry, era;
        logic        e_re, e_we;
        logic [13:0] e_num;
        logic [31:0] e_mask, e_wval;
        logic        e_rfwe;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata;
        logic        e_ex;
        logic [5:0]  e_ecode;
        logic [8:0]  e_esub;
        logic [31:0] e_vaddr;
        logic        e_ertn, e_flush;
        logic [31:0] e_target;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];
    vec_t sb [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        mem_valid = 1'b1; mem_op = v.op; mem_pc = v.pc; mem_csr_num = v.num;
        mem_rj_value = v.rj; mem_rkd_value = v.rkd; mem_rf_we = v.rfwe; mem_dest = v.dest;
        mem_result = v.result; mem_ex = v.ex; mem_ecode = v.ecode; mem_esubcode = v.esub;
        mem_vaddr = v.vaddr; has_int = v.hint; csr_rvalue = v.rvalue;
        ex_entry = v.entry; csr_era = v.era;
    endtask

    task automatic check_commit(input vec_t e, input int idx);
        string t;
        t = $sformatf("v%0d", idx);
        chk({t, ".wb_pc"}, wb_pc, e.pc);
        chk({t, ".csr_re"}, 32'(csr_re), 32'(e.e_re));
        chk({t, ".csr_we"}, 32'(csr_we), 32'(e.e_we));
        chk({t, ".csr_num"}, 32'(csr_num), 32'(e.e_num));
        chk({t, ".csr_wmask"}, csr_wmask, e.e_mask);
        chk({t, ".csr_wvalue"}, csr_wvalue, e.e_wval);
        chk({t, ".rf_we"}, 32'(rf_we), 32'(e.e_rfwe));
        chk({t, ".rf_waddr"}, 32'(rf_waddr), 32'(e.e_waddr));
        chk({t, ".rf_wdata"}, rf_wdata, e.e_wdata);
        chk({t, ".wb_ex"}, 32'(wb_ex), 32'(e.e_ex));
        chk({t, ".wb_ecode"}, 32'(wb_ecode), 32'(e.e_ecode));
        chk({t, ".wb_esubcode"}, 32'(wb_esubcode), 32'(e.e_esub));
        chk({t, ".wb_vaddr"}, wb_vaddr, e.e_vaddr);
        chk({t, ".ertn_flush"}, 32'(ertn_flush), 32'(e.e_ertn));
        chk({t, ".flush"}, 32'(flush), 32'(e.e_flush));
        chk({t, ".flush_target"}, flush_target, e.e_target);
    endtask

    task automatic go_idle();
        mem_valid = 1'b0; has_int = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        vec_t e;
        // CSRWR: full mask, old CSR value to rd
        v = '0; v.op = 3'd2; v.pc = 32'h1C00_0000; v.num = 14'h30; v.rkd = 32'hDEAD_BEEF;
        v.rfwe = 1; v.dest = 5; v.result = 32'h55; v.rvalue = 32'h1234;
        v.e_re = 1; v.e_we = 1; v.e_num = 14'h30; v.e_mask = 32'hFFFF_FFFF;
        v.e_wval = 32'hDEAD_BEEF; v.e_rfwe = 1; v.e_waddr = 5; v.e_wdata = 32'h1234;
        vecs[0] = v;
        // CSRXCHG: mask/value passed through
        v = '0; v.op = 3'd3; v.pc = 32'h1C00_0004; v.num = 14'h6; v.rj = 32'h0000_FF00;
        v.rkd = 32'hAAAA_AAAA; v.rfwe = 1; v.dest = 7; v.rvalue = 32'h77;
        v.e_re = 1; v.e_we = 1; v.e_num = 14'h6; v.e_mask = 32'h0000_FF00;
        v.e_wval = 32'hAAAA_AAAA; v.e_rfwe = 1; v.e_waddr = 7; v.e_wdata = 32'h77;
        vecs[1] = v;
        // CSRRD: read only
        v = '0; v.op = 3'd1; v.pc = 32'h1C00_0008; v.num = 14'h1; v.rfwe = 1; v.dest = 3;
        v.rkd = 32'h1111_2222; v.rvalue = 32'hCAFE;
        v.e_re = 1; v.e_num = 14'h1; v.e_rfwe = 1; v.e_waddr = 3; v.e_wdata = 32'hCAFE;
        vecs[2] = v;
        // plain op to r0: no GPR write
        v = '0; v.pc = 32'h1C00_000C; v.rfwe = 1; v.dest = 0; v.result = 32'h99;
        v.e_wdata = 32'h99;
        vecs[3] = v;
        // unknown op 5 behaves as NONE
        v = '0; v.op = 3'd5; v.pc = 32'h1C00_0010; v.num = 14'h30; v.rfwe = 1; v.dest = 2;
        v.result = 32'h0ABC; v.rvalue = 32'hFFFF;
        v.e_rfwe = 1; v.e_waddr = 2; v.e_wdata = 32'h0ABC;
        vecs[4] = v;
        // CSRXCHG with upstream exception: no CSR/GPR write, flush to entry
        v = '0; v.op = 3'd3; v.pc = 32'h1C00_0014; v.num = 14'h6; v.rj = 32'h0000_FF00;
        v.rkd = 32'hAAAA_AAAA; v.rfwe = 1; v.dest = 7; v.ex = 1; v.ecode = 6'h0B;
        v.esub = 9'h005; v.rvalue = 32'h77; v.entry = 32'h1C00_8000;
        v.e_num = 14'h6; v.e_mask = 32'h0000_FF00; v.e_waddr = 7; v.e_wdata = 32'h77;
        v.e_ex = 1; v.e_ecode = 6'h0B; v.e_esub = 9'h005; v.e_flush = 1;
        v.e_target = 32'h1C00_8000;
        vecs[5] = v;
        // ALE with bad vaddr
        v = '0; v.pc = 32'h1C00_0018; v.rfwe = 1; v.dest = 4; v.result = 32'h4;
        v.ex = 1; v.ecode = 6'h09; v.vaddr = 32'h8000_0003; v.entry = 32'h1C00_8000;
        v.e_waddr = 4; v.e_wdata = 32'h4; v.e_ex = 1; v.e_ecode = 6'h09;
        v.e_vaddr = 32'h8000_0003; v.e_flush = 1; v.e_target = 32'h1C00_8000;
        vecs[6] = v;
        // ERTN redirects to ERA
        v = '0; v.op = 3'd4; v.pc = 32'h1C00_001C; v.entry = 32'h1C00_8000;
        v.era = 32'h1C00_0100;
        v.e_ertn = 1; v.e_flush = 1; v.e_target = 32'h1C00_0100;
        vecs[7] = v;
        // interrupt on ERTN: exception wins, ertn suppressed
        v = '0; v.op = 3'd4; v.pc = 32'h1C00_0020; v.hint = 1; v.entry = 32'h1C00_8000;
        v.era = 32'h1C00_0100;
        v.e_ex = 1; v.e_flush = 1; v.e_target = 32'h1C00_8000;
        vecs[8] = v;
        // interrupt over upstream exception on CSRWR: ecode/vaddr forced to 0
        v = '0; v.op = 3'd2; v.pc = 32'h1C00_0024; v.num = 14'h30; v.rkd = 32'h5;
        v.rfwe = 1; v.dest = 5; v.ex = 1; v.ecode = 6'h0B; v.esub = 9'h3;
        v.vaddr = 32'h1234; v.hint = 1; v.rvalue = 32'h1; v.entry = 32'h1C00_8000;
        v.e_num = 14'h30; v.e_mask = 32'hFFFF_FFFF; v.e_waddr = 5; v.e_wdata = 32'h1;
        v.e_ex = 1; v.e_flush = 1; v.e_target = 32'h1C00_8000;
        vecs[9] = v;

        // reset with live inputs: outputs held at 0, allowin 1
        resetn = 1'b0;
        drive(vecs[0]);
        has_int = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.wb_allowin", 32'(wb_allowin), 32'd1);
        chk("reset.rf_we", 32'(rf_we), 32'd0);
        chk("reset.wb_ex", 32'(wb_ex), 32'd0);
        chk("reset.wb_pc", wb_pc, 32'h0);
        chk("reset.csr_we", 32'(csr_we), 32'd0);
        chk("reset.rf_wdata", rf_wdata, 32'h0);
        chk("reset.flush", 32'(flush), 32'd0);
        @(negedge clk);
        go_idle();
        resetn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            sb.push_back(vecs[i]);
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                chk("scoreboard_empty", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check_commit(e, i);
            end
            @(negedge clk);
            go_idle();
            if (vecs[i].e_flush) repeat (4) @(negedge clk);
        end

        // ERTN then 3 discarded instructions, 4th commits; has_int ignored while draining
        drive(vecs[7]);
        @(posedge clk);
        #1;
        chk("drain.ertn_flush", 32'(ertn_flush), 32'd1);
        chk("drain.target", flush_target, 32'h1C00_0100);
        @(negedge clk);
        go_idle();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            v = '0; v.pc = 32'h2000_0000 + 32'(k * 4); v.rfwe = 1; v.dest = 1;
            v.result = 32'(k + 1);
            drive(v);
            has_int = 1'b1;
            @(posedge clk);
            #1;
            chk($sformatf("drain%0d.rf_we", k), 32'(rf_we), 32'd0);
            chk($sformatf("drain%0d.wb_pc", k), wb_pc, 32'h0);
            chk($sformatf("drain%0d.wb_ex", k), 32'(wb_ex), 32'd0);
        end
        @(negedge clk);
        v = '0; v.pc = 32'h2000_0010; v.rfwe = 1; v.dest = 1; v.result = 32'h44;
        drive(v);
        @(posedge clk);
        #1;
        chk("drain4.rf_we", 32'(rf_we), 32'd1);
        chk("drain4.rf_wdata", rf_wdata, 32'h44);
        chk("drain4.wb_pc", wb_pc, 32'h2000_0010);
        chk("drain4.flush", 32'(flush), 32'd0);

        // has_int while nothing commits
        @(negedge clk);
        go_idle();
        @(posedge clk);
        #1;
        has_int = 1'b1;
        #1;
        chk("idle_int.wb_ex", 32'(wb_ex), 32'd0);
        chk("idle_int.flush", 32'(flush), 32'd0);

        // reset asserted with drain_cnt at 2, then first instruction after release commits
        @(negedge clk);
        drive(vecs[7]);
        @(negedge clk);
        go_idle();
        @(negedge clk);
        v = '0; v.pc = 32'h3000_0000; v.rfwe = 1; v.dest = 6; v.result = 32'h11;
        drive(v);
        @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        chk("rst_drain.wb_allowin", 32'(wb_allowin), 32'd1);
        chk("rst_drain.rf_we", 32'(rf_we), 32'd0);
        chk("rst_drain.wb_pc", wb_pc, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        v = '0; v.pc = 32'h3000_0004; v.rfwe = 1; v.dest = 6; v.result = 32'h66;
        drive(v);
        @(posedge clk);
        #1;
        chk("rst_drain.post_rf_we", 32'(rf_we), 32'd1);
        chk("rst_drain.post_wdata", rf_wdata, 32'h66);
        chk("rst_drain.post_pc", wb_pc, 32'h3000_0004);
        @(negedge clk);
        go_idle();
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_csr_commit.md
Name: wb_csr_commit

Overview:
- Write-back stage commit controller for the LoongArch pipeline; the initiator side of the CSR register-file port.
- Latches instructions from MEM and drives all CSR file inputs: read/write request, exception report, ertn.
- Consumes has_int, ex_entry and ERA from the CSR file, tags interrupts and drives regfile write-back.
- Issues the pipeline flush/redirect and drains in-flight wrong-path instructions.

Parameters:
- DRAIN_CYCLES, 3, cycles after a flush during which incoming MEM instructions are accepted and discarded (1..15).
- CNT_W, 4, width of the drain counter.

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
mem_valid  in  1  MEM stage holds a valid instruction
wb_allowin  out  1  WB can accept (always 1; dropped inputs are discarded, not stalled)
mem_pc  in  32  instruction PC
mem_op  in  3  0 NONE, 1 CSRRD, 2 CSRWR, 3 CSRXCHG, 4 ERTN; others treated as NONE
mem_csr_num  in  14  CSR number
mem_rj_value  in  32  csrxchg write mask
mem_rkd_value  in  32  csrwr/csrxchg write data
mem_rf_we  in  1  instruction writes the GPR file
mem_dest  in  5  GPR destination
mem_result  in  32  ALU/load result
mem_ex  in  1  exception raised upstream
mem_ecode  in  6  upstream ecode
mem_esubcode  in  9  upstream esubcode
mem_vaddr  in  32  faulting address (ALE/ADEF)
csr_re, csr_we  out  1 each  CSR file read/write strobes
csr_num  out  14  CSR number
csr_wmask, csr_wvalue  out  32 each  CSR write mask/data
csr_rvalue  in  32  CSR read data (combinational)
wb_pc  out  32  committing PC
wb_ex  out  1  exception commit
wb_ecode  out  6  ecode
wb_esubcode  out  9  esubcode
wb_vaddr  out  32  bad vaddr
ertn_flush  out  1  ertn commit
has_int  in  1  pending enabled interrupt
ex_entry  in  32  exception entry
csr_era  in  32  ERA value
rf_we  out  1  GPR write enable
rf_waddr  out  5  GPR address
rf_wdata  out  32  GPR data
flush  out  1  one-cycle pipeline flush
flush_target  out  32  redirect PC

Behaviour:
- Reset (resetn low, async):
  - wb_valid=0, state RUN, drain_cnt=0, all WB payload registers 0.
  - Every output except wb_allowin is 0 during reset; wb_allowin=1 during reset.
- Capture:
  - On posedge, if mem_valid and state RUN, load payload and set wb_valid=1; otherwise wb_valid=0.
  - WB completes in one cycle, so every instruction commits in the cycle after capture.
- Commit cycle (wb_valid=1), all combinational:
  - Interrupt: int_take=has_int.
  - Exception: ex=int_take|reg_ex.
  - Priority: interrupt > upstream exception > ertn > CSR op.
  - With int_take: ecode=0x00, esubcode=0, vaddr=0. Otherwise ecode/esubcode/vaddr come from the latched values.
  - wb_ex=ex, wb_pc=latched pc.
  - ertn_flush=(op==ERTN)&~ex.
  - csr_re=(op in CSRRD/WR/XCHG)&~ex; csr_num=latched num (0 when not a CSR op).
  - csr_we=(op in CSRWR/XCHG)&~ex.
  - csr_wmask: CSRWR 0xFFFFFFFF, CSRXCHG rj_value, else 0.
  - csr_wvalue=rkd_value when csr_we, else 0.
  - rf_we=reg_rf_we&~ex&(dest!=0).
  - rf_wdata=csr_rvalue for CSR ops (old value), else result.
- Flush:
  - flush=ex|ertn_flush.
  - flush_target=ex_entry on an exception, csr_era on ertn, else 0.
  - On a flush cycle: state->DRAIN, drain_cnt<=DRAIN_CYCLES.
- DRAIN:
  - Each cycle drain_cnt decrements; mem_valid inputs are accepted (wb_allowin=1) and discarded, with no capture and no side effects.
  - When drain_cnt==1, next state is RUN and drain_cnt=0.
  - has_int is ignored outside commit cycles.
- Simultaneous events:
  - A capture cannot occur in the same edge as entering DRAIN (the flush cycle's edge already sees state RUN but is overridden: flush forces no capture).
  - Reset mid-DRAIN returns to RUN immediately.
- Width rules: CSRXCHG mask/value are passed unmodified; field masking is the CSR file's responsibility.

Test Plan:
- CSRWR num 0x30 rkd=0xDEADBEEF dest=5, csr_rvalue=0x1234 -> commit cycle: csr_we=1, wmask=0xFFFFFFFF, wvalue=0xDEADBEEF, rf_we=1, rf_waddr=5, rf_wdata=0x1234, flush=0.
- CSRXCHG rj=0x0000FF00 rkd=0xAAAAAAAA -> csr_wmask=0x0000FF00, csr_wvalue=0xAAAAAAAA; same op with mem_ex=1 ecode 0x0B -> csr_we=0, rf_we=0, wb_ex=1, wb_ecode=0x0B, flush=1, flush_target=ex_entry.
- ERTN with csr_era=0x1C000100 -> ertn_flush=1, flush_target=0x1C000100; next 3 mem_valid instructions discarded (no rf_we), the 4th commits.
- has_int=1 on a valid ERTN commit -> wb_ex=1, ecode=0, ertn_flush=0, flush_target=ex_entry.
- ALE exception with vaddr=0x80000003 -> wb_vaddr=0x80000003, wb_ecode=0x09; has_int=1 while wb_valid=0 -> no wb_ex.
- resetn low asserted mid-DRAIN (cnt=2) -> all outputs 0 immediately; after release, the first mem_valid instruction is captured and commits next cycle.
